// File: rtl/prt_dptx_sts_msg.sv
// DP TX status message master: frames link status and event pulses into two-word messages.
// Optional heartbeat re-send is compiled in with `define PRT_DPTX_STS_HEARTBEAT_EN.
module prt_dptx_sts_msg #(
  parameter int         P_MSG_DAT   = 16,
  parameter logic [7:0] P_MSG_ID    = 8'h00,
  parameter int         P_STS_WIDTH = 8,
  parameter int         P_EVT_WIDTH = 8,
  parameter int         P_HB_PERIOD = 65535
) (
  input  logic                   CLK_IN,
  input  logic                   RST_N_IN,
  input  logic [P_STS_WIDTH-1:0] STS_IN,
  input  logic [P_EVT_WIDTH-1:0] EVT_IN,
  input  logic                   REQ_IN,
  output logic                   MSG_SOM_OUT,
  output logic                   MSG_EOM_OUT,
  output logic [P_MSG_DAT-1:0]   MSG_DAT_OUT,
  output logic                   MSG_VLD_OUT,
  input  logic                   MSG_RDY_IN,
  output logic                   BUSY_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DAT  = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [P_STS_WIDTH-1:0] sts_q_reg;
  logic [P_STS_WIDTH-1:0] sts_sent_reg;
  logic [P_EVT_WIDTH-1:0] evt_pend_reg;
  logic                   req_pend_reg;
  logic [7:0]             seq_reg;
  logic [P_MSG_DAT-1:0]   snap_reg;
  logic                   vld_reg;
  logic                   som_reg;
  logic                   eom_reg;
  logic [P_MSG_DAT-1:0]   dat_reg;
  logic [7:0]             sts_ext;
  logic [7:0]             evt_ext;
  logic                   hb_expire;
  logic                   trigger;

  // Both payload bytes are zero-extended to 8 bits regardless of configured widths.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ext
      if (gi < P_STS_WIDTH) begin : g_sts
        assign sts_ext[gi] = sts_q_reg[gi];
      end else begin : g_sts_pad
        assign sts_ext[gi] = 1'b0;
      end
      if (gi < P_EVT_WIDTH) begin : g_evt
        assign evt_ext[gi] = evt_pend_reg[gi];
      end else begin : g_evt_pad
        assign evt_ext[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef PRT_DPTX_STS_HEARTBEAT_EN
  logic [15:0] hb_cnt_reg;

  // Expires on the IDLE clock whose increment would reach P_HB_PERIOD-1, giving a
  // P_HB_PERIOD+1 clock message cadence including the two message clocks.
  assign hb_expire = (state_reg == ST_IDLE) &&
                     ((hb_cnt_reg + 16'd1) == 16'(P_HB_PERIOD - 1));

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      hb_cnt_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      if (trigger) begin
        hb_cnt_reg <= '0;
      end else begin
        hb_cnt_reg <= hb_cnt_reg + 16'd1;
      end
    end
  end
`else
  logic unused_hb_period;
  assign unused_hb_period = (P_HB_PERIOD != 0);
  assign hb_expire        = 1'b0;
`endif

  assign trigger = (sts_q_reg != sts_sent_reg) | (|evt_pend_reg) | req_pend_reg | hb_expire;

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state_reg    <= ST_IDLE;
      sts_q_reg    <= '0;
      sts_sent_reg <= '0;
      evt_pend_reg <= '0;
      req_pend_reg <= 1'b0;
      seq_reg      <= '0;
      snap_reg     <= '0;
      vld_reg      <= 1'b0;
      som_reg      <= 1'b0;
      eom_reg      <= 1'b0;
      dat_reg      <= '0;
    end else begin
      sts_q_reg    <= STS_IN;
      evt_pend_reg <= evt_pend_reg | EVT_IN;
      req_pend_reg <= req_pend_reg | REQ_IN;
      case (state_reg)
        ST_IDLE: begin
          if (trigger) begin
            state_reg    <= ST_HDR;
            snap_reg     <= {evt_ext, sts_ext};
            sts_sent_reg <= sts_q_reg;
            // Pulses landing on the snapshot edge belong to the next message.
            evt_pend_reg <= EVT_IN;
            req_pend_reg <= REQ_IN;
            vld_reg      <= 1'b1;
            som_reg      <= 1'b1;
            dat_reg      <= {P_MSG_ID, seq_reg};
          end
        end
        ST_HDR: begin
          if (MSG_RDY_IN) begin
            state_reg <= ST_DAT;
            som_reg   <= 1'b0;
            eom_reg   <= 1'b1;
            dat_reg   <= snap_reg;
          end
        end
        ST_DAT: begin
          if (MSG_RDY_IN) begin
            state_reg <= ST_IDLE;
            vld_reg   <= 1'b0;
            eom_reg   <= 1'b0;
            dat_reg   <= '0;
            seq_reg   <= seq_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          vld_reg   <= 1'b0;
          som_reg   <= 1'b0;
          eom_reg   <= 1'b0;
          dat_reg   <= '0;
        end
      endcase
    end
  end

  assign MSG_VLD_OUT = vld_reg;
  assign MSG_SOM_OUT = som_reg;
  assign MSG_EOM_OUT = eom_reg;
  assign MSG_DAT_OUT = dat_reg;
  assign BUSY_OUT    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_prt_dptx_sts_msg.sv
// Directed bench for prt_dptx_sts_msg: status, event, request, coalescing, wrap and reset scenarios.
module tb_prt_dptx_sts_msg;

  localparam logic [7:0] ID = 8'hA5;

  logic        CLK_IN = 1'b0;
  logic        RST_N_IN;
  logic [7:0]  STS_IN;
  logic [7:0]  EVT_IN;
  logic        REQ_IN;
  logic        MSG_SOM_OUT;
  logic        MSG_EOM_OUT;
  logic [15:0] MSG_DAT_OUT;
  logic        MSG_VLD_OUT;
  logic        MSG_RDY_IN;
  logic        BUSY_OUT;

  int checks = 0;
  int passed = 0;

  prt_dptx_sts_msg #(
    .P_MSG_DAT  (16),
    .P_MSG_ID   (ID),
    .P_STS_WIDTH(8),
    .P_EVT_WIDTH(8),
    .P_HB_PERIOD(16)
  ) dut (
    .CLK_IN     (CLK_IN),
    .RST_N_IN   (RST_N_IN),
    .STS_IN     (STS_IN),
    .EVT_IN     (EVT_IN),
    .REQ_IN     (REQ_IN),
    .MSG_SOM_OUT(MSG_SOM_OUT),
    .MSG_EOM_OUT(MSG_EOM_OUT),
    .MSG_DAT_OUT(MSG_DAT_OUT),
    .MSG_VLD_OUT(MSG_VLD_OUT),
    .MSG_RDY_IN (MSG_RDY_IN),
    .BUSY_OUT   (BUSY_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Inputs are driven and outputs sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic test_reset();
    int vld_cnt;
    RST_N_IN = 1'b0; STS_IN = 8'h00; EVT_IN = 8'h00; REQ_IN = 1'b0; MSG_RDY_IN = 1'b1;
    repeat (3) tick();
    checks++;
    if ({MSG_VLD_OUT, MSG_SOM_OUT, MSG_EOM_OUT, BUSY_OUT, MSG_DAT_OUT} !== 20'h0)
      $display("FAIL reset_outputs: got vld=%b som=%b eom=%b busy=%b dat=%h, expected all 0",
               MSG_VLD_OUT, MSG_SOM_OUT, MSG_EOM_OUT, BUSY_OUT, MSG_DAT_OUT);
    else passed++;
    RST_N_IN = 1'b1;
    vld_cnt = 0;
    repeat (100) begin
      tick();
      if (MSG_VLD_OUT !== 1'b0) vld_cnt++;
    end
    checks++;
    if (vld_cnt != 0) $display("FAIL idle_after_reset: got %0d valid cycles, expected 0", vld_cnt);
    else passed++;
  endtask

  task automatic test_status_change();
    STS_IN = 8'h05;
    tick();
    checks++;
    if (MSG_VLD_OUT !== 1'b0) $display("FAIL sts_latency: got vld=%b after 1 clock, expected 0", MSG_VLD_OUT);
    else passed++;
    tick();
    checks++;
    if ({MSG_VLD_OUT, MSG_SOM_OUT, MSG_EOM_OUT, BUSY_OUT} !== 4'b1101 || MSG_DAT_OUT !== {ID, 8'h00})
      $display("FAIL sts_hdr: got vld/som/eom/busy=%b dat=%h, expected 1101 dat=%h",
               {MSG_VLD_OUT, MSG_SOM_OUT, MSG_EOM_OUT, BUSY_OUT}, MSG_DAT_OUT, {ID, 8'h00});
    else passed++;
    tick();
    checks++;
    if ({MSG_VLD_OUT, MSG_SOM_OUT, MSG_EOM_OUT} !== 3'b101 || MSG_DAT_OUT !== 16'h0005)
      $display("FAIL sts_dat: got vld/som/eom=%b dat=%h, expected 101 dat=0005",
               {MSG_VLD_OUT, MSG_SOM_OUT, MSG_EOM_OUT}, MSG_DAT_OUT);
    else passed++;
    tick();
    checks++;
    if ({MSG_VLD_OUT, BUSY_OUT} !== 2'b00)
      $display("FAIL sts_done: got vld=%b busy=%b, expected 0 0", MSG_VLD_OUT, BUSY_OUT);
    else passed++;
  endtask

  task automatic test_evt_during_hdr();
    bit stable;
    int vld_cnt;
    MSG_RDY_IN = 1'b0;
    REQ_IN = 1'b1;
    tick();
    REQ_IN = 1'b0;
    tick();
    checks++;
    if ({MSG_VLD_OUT, MSG_SOM_OUT} !== 2'b11 || MSG_DAT_OUT !== {ID, 8'h01})
      $display("FAIL req_hdr: got vld/som=%b dat=%h, expected 11 dat=%h",
               {MSG_VLD_OUT, MSG_SOM_OUT}, MSG_DAT_OUT, {ID, 8'h01});
    else passed++;
    EVT_IN = 8'h02;
    tick();
    EVT_IN = 8'h00;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!(MSG_VLD_OUT === 1'b1 && MSG_SOM_OUT === 1'b1 && MSG_DAT_OUT === {ID, 8'h01})) stable = 1'b0;
    end
    checks++;
    if (!stable) $display("FAIL hdr_hold: got dat=%h som=%b while stalled, expected %h held", MSG_DAT_OUT, MSG_SOM_OUT, {ID, 8'h01});
    else passed++;
    MSG_RDY_IN = 1'b1;
    tick();
    checks++;
    if (MSG_EOM_OUT !== 1'b1 || MSG_DAT_OUT !== 16'h0005)
      $display("FAIL evt_first_dat: got eom=%b dat=%h, expected 1 dat=0005", MSG_EOM_OUT, MSG_DAT_OUT);
    else passed++;
    tick();
    checks++;
    if (MSG_VLD_OUT !== 1'b0) $display("FAIL evt_gap: got vld=%b, expected 0", MSG_VLD_OUT);
    else passed++;
    tick();
    checks++;
    if (MSG_SOM_OUT !== 1'b1 || MSG_DAT_OUT !== {ID, 8'h02})
      $display("FAIL evt_hdr: got som=%b dat=%h, expected 1 dat=%h", MSG_SOM_OUT, MSG_DAT_OUT, {ID, 8'h02});
    else passed++;
    tick();
    checks++;
    if (MSG_EOM_OUT !== 1'b1 || MSG_DAT_OUT !== 16'h0205)
      $display("FAIL evt_dat: got eom=%b dat=%h, expected 1 dat=0205", MSG_EOM_OUT, MSG_DAT_OUT);
    else passed++;
    vld_cnt = 0;
    repeat (10) begin
      tick();
      if (MSG_VLD_OUT !== 1'b0) vld_cnt++;
    end
    checks++;
    if (vld_cnt != 0) $display("FAIL evt_cleared: got %0d valid cycles, expected 0", vld_cnt);
    else passed++;
  endtask

  task automatic test_coalesce();
    int vld_cnt;
    MSG_RDY_IN = 1'b0;
    REQ_IN = 1'b1;
    tick();
    REQ_IN = 1'b0;
    tick();
    STS_IN = 8'h06;
    repeat (2) tick();
    STS_IN = 8'h05;
    repeat (2) tick();
    MSG_RDY_IN = 1'b1;
    tick();
    checks++;
    if (MSG_EOM_OUT !== 1'b1 || MSG_DAT_OUT !== 16'h0005)
      $display("FAIL coal_dat: got eom=%b dat=%h, expected 1 dat=0005", MSG_EOM_OUT, MSG_DAT_OUT);
    else passed++;
    vld_cnt = 0;
    repeat (10) begin
      tick();
      if (MSG_VLD_OUT !== 1'b0) vld_cnt++;
    end
    checks++;
    if (vld_cnt != 0) $display("FAIL coal_no_extra: got %0d valid cycles, expected 0", vld_cnt);
    else passed++;
    STS_IN = 8'h06;
    tick();
    tick();
    checks++;
    if (MSG_SOM_OUT !== 1'b1 || MSG_DAT_OUT !== {ID, 8'h04})
      $display("FAIL coal_hdr: got som=%b dat=%h, expected 1 dat=%h", MSG_SOM_OUT, MSG_DAT_OUT, {ID, 8'h04});
    else passed++;
    tick();
    checks++;
    if (MSG_EOM_OUT !== 1'b1 || MSG_DAT_OUT !== 16'h0006)
      $display("FAIL coal_dat6: got eom=%b dat=%h, expected 1 dat=0006", MSG_EOM_OUT, MSG_DAT_OUT);
    else passed++;
    vld_cnt = 0;
    repeat (10) begin
      tick();
      if (MSG_VLD_OUT !== 1'b0) vld_cnt++;
    end
    checks++;
    if (vld_cnt != 0) $display("FAIL coal_single: got %0d valid cycles, expected 0", vld_cnt);
    else passed++;
  endtask

  task automatic test_seq_wrap();
    logic [7:0] exp_seq;
    RST_N_IN = 1'b0; STS_IN = 8'h00; MSG_RDY_IN = 1'b1;
    repeat (2) tick();
    RST_N_IN = 1'b1;
    tick();
    for (int i = 0; i < 257; i++) begin
      exp_seq = 8'(i);
      REQ_IN = 1'b1;
      tick();
      REQ_IN = 1'b0;
      tick();
      checks++;
      if (MSG_SOM_OUT !== 1'b1 || MSG_DAT_OUT !== {ID, exp_seq})
        $display("FAIL seq_hdr[%0d]: got som=%b dat=%h, expected 1 dat=%h", i, MSG_SOM_OUT, MSG_DAT_OUT, {ID, exp_seq});
      else passed++;
      tick();
      tick();
    end
    checks++;
    if (MSG_VLD_OUT !== 1'b0) $display("FAIL seq_end: got vld=%b, expected 0", MSG_VLD_OUT);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int vld_cnt;
    MSG_RDY_IN = 1'b0;
    STS_IN = 8'h03;
    tick();
    tick();
    MSG_RDY_IN = 1'b1;
    tick();
    MSG_RDY_IN = 1'b0;
    tick();
    checks++;
    if (MSG_EOM_OUT !== 1'b1 || MSG_DAT_OUT !== 16'h0003)
      $display("FAIL mid_dat: got eom=%b dat=%h, expected 1 dat=0003", MSG_EOM_OUT, MSG_DAT_OUT);
    else passed++;
    RST_N_IN = 1'b0;
    #1;
    checks++;
    if ({MSG_VLD_OUT, MSG_SOM_OUT, MSG_EOM_OUT, BUSY_OUT, MSG_DAT_OUT} !== 20'h0)
      $display("FAIL mid_reset: got vld=%b som=%b eom=%b busy=%b dat=%h, expected all 0",
               MSG_VLD_OUT, MSG_SOM_OUT, MSG_EOM_OUT, BUSY_OUT, MSG_DAT_OUT);
    else passed++;
    STS_IN = 8'h00;
    MSG_RDY_IN = 1'b1;
    repeat (2) tick();
    RST_N_IN = 1'b1;
    vld_cnt = 0;
    repeat (20) begin
      tick();
      if (MSG_VLD_OUT !== 1'b0) vld_cnt++;
    end
    checks++;
    if (vld_cnt != 0) $display("FAIL mid_residual: got %0d valid cycles, expected 0", vld_cnt);
    else passed++;
  endtask

  task automatic test_heartbeat();
    int som_pos[$];
    RST_N_IN = 1'b0; STS_IN = 8'h00; EVT_IN = 8'h00; REQ_IN = 1'b0; MSG_RDY_IN = 1'b1;
    repeat (2) tick();
    RST_N_IN = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (MSG_SOM_OUT === 1'b1) som_pos.push_back(i);
    end
`ifdef PRT_DPTX_STS_HEARTBEAT_EN
    checks++;
    if (som_pos.size() != 4) $display("FAIL hb_count: got %0d headers, expected 4", som_pos.size());
    else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= som_pos.size() || som_pos[k] != 15 + 17 * k)
        $display("FAIL hb_pos[%0d]: got %0d, expected %0d", k, (k < som_pos.size()) ? som_pos[k] : -1, 15 + 17 * k);
      else passed++;
    end
`else
    checks++;
    if (som_pos.size() != 0) $display("FAIL hb_absent: got %0d headers, expected 0", som_pos.size());
    else passed++;
`endif
  endtask

  initial begin
    RST_N_IN = 1'b0; STS_IN = 8'h00; EVT_IN = 8'h00; REQ_IN = 1'b0; MSG_RDY_IN = 1'b1;
`ifdef PRT_DPTX_STS_HEARTBEAT_EN
    test_heartbeat();
`else
    test_reset();
    test_status_change();
    test_evt_during_hdr();
    test_coalesce();
    test_seq_wrap();
    test_reset_mid();
    test_heartbeat();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
